board_scan_checker: RTL and testbench
=====================================

# board_scan_checker

Sequential five-in-a-row detector for the 16x16 gomoku board. It reads the 512-bit packed board vector produced by the board write path, snapshots it on `start`, and scans every cell as a line origin, one cell per cycle. It reports the winner and the first winning line found. It sits beside the board memory as a registered, fixed-latency alternative to the combinational whole-board check, and feeds the win LEDs and the VGA overlay.

## Interface
Parameters:
- `BOARD_N`, default 16: board side length in cells. Row and column indices are 4 bits at the default.
- `WIN_LEN`, default 5: number of consecutive same-colour stones that constitutes a win.

Ports:
- `clock`  in  1: the only clock. Everything is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request to check the board. Sampled only in IDLE.
- `board`  in  2*BOARD_N*BOARD_N: packed board.
  - Cell index `idx = row*BOARD_N + col`; the cell occupies bits `[2*idx+1 : 2*idx]`.
  - Encoding: 00 empty, 01 player0, 10 player1, 11 treated as empty.
- `busy`  out  1: high while a scan is in progress.
- `done`  out  1: one-cycle pulse when the result registers update.
- `ans`  out  2: result. 00 no win, 01 player0 win, 10 player1 win, 11 both players have a line.
- `win_row`  out  4: row of the origin of the first winning line, in scan order.
- `win_col`  out  4: column of that origin.
- `win_dir`  out  2: direction of that line. 00 E (col+1), 01 S (row+1), 10 SE (row+1, col+1), 11 SW (row+1, col-1).

## Operation
- States:
  - IDLE: waits for `start`.
  - SCAN: visits cells 0 to BOARD_N²-1.
  - DONE: lasts one cycle, pulses `done`, returns to IDLE.
- On `start` in IDLE:
  - Latch `board` into a snapshot register.
  - Clear the cell counter, the hit flags and the first-hit record.
  - Changes to `board` during SCAN have no effect.
- Each SCAN cycle, the cell at counter `c` is the origin. For each of the four directions:
  - A line is a hit when all WIN_LEN cells hold the same non-empty colour.
  - A direction whose end cell falls off the board is not checked. E needs col ≤ BOARD_N-WIN_LEN; S needs row ≤ BOARD_N-WIN_LEN; SE needs both; SW needs row ≤ BOARD_N-WIN_LEN and col ≥ WIN_LEN-1.
  - There is no wrap-around between rows or between edges.
- Overlines (six or more in a row) produce hits at several origins and count as a win.
- Hit handling:
  - Set `p0_hit` or `p1_hit` according to the colour of the line.
  - The first hit in scan order records row, column and direction.
  - Order within a cell when several directions hit: E, then S, then SE, then SW.
- On entry to DONE:
  - `ans = {p1_hit, p0_hit}`.
  - If there was no hit, `win_row`, `win_col` and `win_dir` are 0.
- Result outputs hold their value until the next DONE or reset. `start` does not clear them.
- `start` while `busy` or in DONE is ignored. It is not queued.
- Counter arithmetic: 8-bit counter at the default. The terminal count is BOARD_N²-1, then SCAN moves to DONE with no overflow. Row is `c[7:4]`, column is `c[3:0]`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `ans` 00, `win_row`/`win_col`/`win_dir` 0, snapshot 0, counter 0.
- `start` high in cycle t (IDLE):
  - `busy` is 1 in cycles t+1 to t+256.
  - The cell with index k is evaluated in cycle t+1+k.
  - `done` is 1 in cycle t+257, with the new `ans` and `win_*` valid in that same cycle.
  - The earliest accepted restart is a `start` in cycle t+258.
- Fixed latency of BOARD_N²+1 cycles from `start` to `done`. There is no early exit.
- `reset` asserted in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - An in-flight scan is discarded and no `done` is produced.
- `reset` and `start` high in the same cycle: reset wins and the start is dropped.

## Structure
- Shared package `five_pkg` holds:
  - Cell encoding constants: `CELL_EMPTY`, `CELL_P0`, `CELL_P1`.
  - Direction codes: `DIR_E`, `DIR_S`, `DIR_SE`, `DIR_SW`.
  - Default `BOARD_N` and `WIN_LEN`.
  - A cell-extract function `cell_at(board, row, col)`.
- One sub-module, `line_probe`, is combinational:
  - Inputs: snapshot, origin row and column.
  - Outputs: 4-bit hit vector and 4×2-bit colour vector.
- The top level holds the FSM, counter, snapshot and result registers.

## Test plan
- Empty board, `start` at t: `busy` high t+1 to t+256, `done` at t+257 with `ans=00` and `win_*=0`.
- Player0 (01) stones at row 3, cols 2–6: `ans=01`, `win_row=3`, `win_col=2`, `win_dir=E`. A second run with the col 6 stone removed gives `ans=00`.
- Edge and wrap check:
  - Player1 at row 2 cols 13–15 plus row 3 cols 0–1 gives `ans=00`.
  - Player1 anti-diagonal (4,10),(5,9),(6,8),(7,7),(8,6) gives `ans=10`, origin (4,10), `win_dir=SW`.
- Player0 vertical at col 0 rows 11–15, plus player1 SE diagonal from (0,0): `ans=11`, first hit is `win_row=0`, `win_col=0`, `win_dir=SE`.
- Snapshot and start handling:
  - Winning line present at `start`, then `board` cleared at t+5: the result is still a win.
  - A second `start` at t+100 is ignored and `done` occurs only at t+257.
- `reset` pulsed at t+50 of a scan on a winning board:
  - All outputs are 0 from t+51 and no `done` follows.
  - A new `start` after reset yields the correct win at the new t+257.

Source files
------------

// File: rtl/five_pkg.sv
// Shared definitions for the gomoku board checkers: cell encoding, line
// directions, default board geometry, FSM states and a cell-extract helper.
package five_pkg;

  localparam int unsigned DEF_BOARD_N = 16;
  localparam int unsigned DEF_WIN_LEN = 5;
  localparam int unsigned BOARD_BITS  = 2 * DEF_BOARD_N * DEF_BOARD_N;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P0    = 2'b01;
  localparam logic [1:0] CELL_P1    = 2'b10;

  typedef enum logic [1:0] {
    DIR_E  = 2'd0,
    DIR_S  = 2'd1,
    DIR_SE = 2'd2,
    DIR_SW = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Colour of (row, col); anything off the board reads as empty.
  function automatic logic [1:0] cell_at(input logic [BOARD_BITS-1:0] board,
                                         input int row, input int col);
    if (row < 0 || col < 0 || row >= int'(DEF_BOARD_N) || col >= int'(DEF_BOARD_N))
      cell_at = CELL_EMPTY;
    else
      cell_at = board[2*(row*int'(DEF_BOARD_N) + col) +: 2];
  endfunction

endpackage

// File: rtl/line_probe.sv
// Combinational probe of the four lines (E, S, SE, SW) starting at one origin.
// Ports: snap  - packed board snapshot
//        row/col - origin cell
//        hit   - per-direction hit, bit index = direction code
//        colour - per-direction line colour, 2 bits per direction
module line_probe import five_pkg::*; #(
  parameter int unsigned BOARD_N = DEF_BOARD_N,
  parameter int unsigned WIN_LEN = DEF_WIN_LEN
) (
  input  logic [2*BOARD_N*BOARD_N-1:0] snap,
  input  logic [$clog2(BOARD_N)-1:0]   row,
  input  logic [$clog2(BOARD_N)-1:0]   col,
  output logic [3:0]                   hit,
  output logic [7:0]                   colour
);

  localparam int LAST_ORIGIN = int'(BOARD_N) - int'(WIN_LEN);

  // All WIN_LEN cells along (dr, dc) hold the same player colour.
  function automatic logic line_hit(input logic [2*BOARD_N*BOARD_N-1:0] b,
                                    input int r0, input int c0,
                                    input int dr, input int dc);
    logic [1:0] first;
    first    = cell_at(b, r0, c0);
    line_hit = (first == CELL_P0) || (first == CELL_P1);
    for (int k = 1; k < int'(WIN_LEN); k++) begin
      if (cell_at(b, r0 + dr*k, c0 + dc*k) != first) line_hit = 1'b0;
    end
  endfunction

  always_comb begin : probe
    int  r;
    int  c;
    logic e_ok, s_ok;
    r      = int'(row);
    c      = int'(col);
    e_ok   = (c <= LAST_ORIGIN);
    s_ok   = (r <= LAST_ORIGIN);
    hit    = '0;
    hit[DIR_E]  = e_ok && line_hit(snap, r, c, 0, 1);
    hit[DIR_S]  = s_ok && line_hit(snap, r, c, 1, 0);
    hit[DIR_SE] = e_ok && s_ok && line_hit(snap, r, c, 1, 1);
    hit[DIR_SW] = s_ok && (c >= int'(WIN_LEN) - 1) && line_hit(snap, r, c, 1, -1);
    // Every line shares the origin cell, so all directions report its colour.
    colour = {4{cell_at(snap, r, c)}};
  end

endmodule

// File: rtl/board_scan_checker.sv
// Sequential five-in-a-row detector: snapshots the board on start, visits one
// origin cell per cycle and reports the winner plus the first winning line.
// Ports: clock/reset - clock and synchronous active-high reset
//        start  - check request, honoured only in IDLE
//        board  - packed 2-bit-per-cell board
//        busy   - scan in progress
//        done   - one-cycle pulse when results update
//        ans    - {p1_hit, p0_hit}
//        win_row/win_col/win_dir - origin and direction of first winning line
module board_scan_checker import five_pkg::*; #(
  parameter int unsigned BOARD_N = DEF_BOARD_N,
  parameter int unsigned WIN_LEN = DEF_WIN_LEN
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2*BOARD_N*BOARD_N-1:0] board,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   ans,
  output logic [$clog2(BOARD_N)-1:0]   win_row,
  output logic [$clog2(BOARD_N)-1:0]   win_col,
  output logic [1:0]                   win_dir
);

  localparam int unsigned ROW_W     = $clog2(BOARD_N);
  localparam int unsigned CNT_W     = 2 * ROW_W;
  localparam int unsigned LAST_CELL = BOARD_N * BOARD_N - 1;

  state_e                       state_q, state_d;
  logic                         busy_d, done_d;
  logic [2*BOARD_N*BOARD_N-1:0] snap;
  logic [CNT_W-1:0]             cnt;
  logic                         p0_hit, p1_hit, found;
  logic [ROW_W-1:0]             rec_row, rec_col;
  logic [1:0]                   rec_dir;

  logic [ROW_W-1:0] cur_row, cur_col;
  logic [3:0]       hit;
  logic [7:0]       colour;
  logic             cur_p0, cur_p1;
  logic [1:0]       cur_dir;
  logic             last_cell;

  assign cur_row   = cnt[CNT_W-1:ROW_W];
  assign cur_col   = cnt[ROW_W-1:0];
  assign last_cell = (cnt == CNT_W'(LAST_CELL));

  line_probe #(.BOARD_N(BOARD_N), .WIN_LEN(WIN_LEN)) u_probe (
    .snap   (snap),
    .row    (cur_row),
    .col    (cur_col),
    .hit    (hit),
    .colour (colour)
  );

  // Colours and priority direction of this cycle's hits (E, S, SE, SW).
  always_comb begin
    cur_p0  = 1'b0;
    cur_p1  = 1'b0;
    cur_dir = DIR_E;
    for (int i = 0; i < 4; i++) begin
      if (hit[i] && colour[2*i +: 2] == CELL_P0) cur_p0 = 1'b1;
      if (hit[i] && colour[2*i +: 2] == CELL_P1) cur_p1 = 1'b1;
    end
    if      (hit[DIR_E])  cur_dir = DIR_E;
    else if (hit[DIR_S])  cur_dir = DIR_S;
    else if (hit[DIR_SE]) cur_dir = DIR_SE;
    else if (hit[DIR_SW]) cur_dir = DIR_SW;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; fixed-length scan with no early exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_SCAN;
      ST_SCAN: if (last_cell) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below.
  always_comb begin
    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Snapshot, counter, hit accumulation and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap    <= '0;
      cnt     <= '0;
      p0_hit  <= 1'b0;
      p1_hit  <= 1'b0;
      found   <= 1'b0;
      rec_row <= '0;
      rec_col <= '0;
      rec_dir <= '0;
      ans     <= '0;
      win_row <= '0;
      win_col <= '0;
      win_dir <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap    <= board;
            cnt     <= '0;
            p0_hit  <= 1'b0;
            p1_hit  <= 1'b0;
            found   <= 1'b0;
            rec_row <= '0;
            rec_col <= '0;
            rec_dir <= '0;
          end
        end
        ST_SCAN: begin
          if (!last_cell) cnt <= cnt + CNT_W'(1);
          p0_hit <= p0_hit | cur_p0;
          p1_hit <= p1_hit | cur_p1;
          if (!found && |hit) begin
            found   <= 1'b1;
            rec_row <= cur_row;
            rec_col <= cur_col;
            rec_dir <= cur_dir;
          end
          // Final cell's hits are folded in directly as results are latched.
          if (last_cell) begin
            ans <= {p1_hit | cur_p1, p0_hit | cur_p0};
            if (found) begin
              win_row <= rec_row;
              win_col <= rec_col;
              win_dir <= rec_dir;
            end else if (|hit) begin
              win_row <= cur_row;
              win_col <= cur_col;
              win_dir <= cur_dir;
            end else begin
              win_row <= '0;
              win_col <= '0;
              win_dir <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_scan_checker.sv
// Directed bench for board_scan_checker with a cycle-level reference model.
module tb_board_scan_checker;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] board;
  logic         busy, done;
  logic [1:0]   ans, win_dir;
  logic [3:0]   win_row, win_col;

  int checks = 0;
  int errors = 0;

  board_scan_checker dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .board   (board),
    .busy    (busy),
    .done    (done),
    .ans     (ans),
    .win_row (win_row),
    .win_col (win_col),
    .win_dir (win_dir)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] get(input logic [511:0] b, input int r, input int c);
    return b[2*(r*16 + c) +: 2];
  endfunction

  function automatic logic [511:0] put(input logic [511:0] b, input int r, input int c,
                                       input logic [1:0] v);
    logic [511:0] t;
    t = b;
    t[2*(r*16 + c) +: 2] = v;
    return t;
  endfunction

  // Whole-board reference: every in-bounds line of five in scan order.
  function automatic void model(input logic [511:0] b, output logic [1:0] a,
                                output int rr, output int cc, output int dd);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    bit found = 0;
    a = 2'b00; rr = 0; cc = 0; dd = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        for (int d = 0; d < 4; d++) begin
          int er, ec;
          logic [1:0] v;
          bit same;
          er = r + 4*dr[d];
          ec = c + 4*dc[d];
          if (er >= 0 && er < 16 && ec >= 0 && ec < 16) begin
            v = get(b, r, c);
            if (v == 2'b01 || v == 2'b10) begin
              same = 1;
              for (int k = 1; k < 5; k++)
                if (get(b, r + k*dr[d], c + k*dc[d]) != v) same = 0;
              if (same) begin
                a = a | v;
                if (!found) begin
                  found = 1; rr = r; cc = c; dd = d;
                end
              end
            end
          end
        end
  endfunction

  // Cycle model of the externally visible behaviour.
  int           m_phase = 0;
  int           m_left  = 0;
  bit           m_live  = 0;
  logic [511:0] m_snap;
  logic         e_busy, e_done;
  logic [1:0]   e_ans;
  int           e_row, e_col, e_dir;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; e_busy = 0; e_done = 0; e_ans = 0;
      e_row = 0; e_col = 0; e_dir = 0; m_live = 1;
    end else begin
      case (m_phase)
        0: begin
          e_done = 0;
          if (start) begin
            m_snap = board; m_phase = 1; m_left = 256; e_busy = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; e_busy = 0; e_done = 1;
            model(m_snap, e_ans, e_row, e_col, e_dir);
          end
        end
        default: begin
          m_phase = 0; e_done = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      check("busy", int'(busy), int'(e_busy));
      check("done", int'(done), int'(e_done));
      check("ans", int'(ans), int'(e_ans));
      check("win_row", int'(win_row), e_row);
      check("win_col", int'(win_col), e_col);
      check("win_dir", int'(win_dir), e_dir);
    end
  end

  // mode: 0 plain, 1 clear board at t+5, 2 extra start at t+100, 3 reset at t+50
  task automatic run_scan(input string name, input logic [511:0] b, input int mode,
                          input int xa, input int xr, input int xc, input int xd);
    int n;
    bit seen;
    board = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    seen = 0;
    while (n < 400) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (mode != 3 && (n == 1 || n == 256)) check({name, "_busy_window"}, int'(busy), 1);
      if (mode == 1 && n == 5) board = '0;
      start = (mode == 2 && n == 100);
      reset = (mode == 3 && n == 50);
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    reset = 1'b0;
    if (mode == 3) begin
      check({name, "_no_done"}, int'(seen), 0);
      check({name, "_ans_cleared"}, int'(ans), 0);
      check({name, "_row_cleared"}, int'(win_row), 0);
    end else begin
      check({name, "_done_seen"}, int'(seen), 1);
      check({name, "_latency"}, n, 257);
      check({name, "_ans"}, int'(ans), xa);
      check({name, "_row"}, int'(win_row), xr);
      check({name, "_col"}, int'(win_col), xc);
      check({name, "_dir"}, int'(win_dir), xd);
      @(negedge clock);
      check({name, "_done_pulse"}, int'(done), 0);
      check({name, "_ans_hold"}, int'(ans), xa);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [511:0] b1, b2, b3, b4, b5, b6, b7;

    b1 = '0;
    for (int c = 2; c <= 6; c++) b1 = put(b1, 3, c, 2'b01);
    b2 = put(b1, 3, 6, 2'b00);
    b3 = '0;
    for (int c = 13; c <= 15; c++) b3 = put(b3, 2, c, 2'b10);
    b3 = put(b3, 3, 0, 2'b10);
    b3 = put(b3, 3, 1, 2'b10);
    b4 = '0;
    for (int k = 0; k < 5; k++) b4 = put(b4, 4 + k, 10 - k, 2'b10);
    b5 = '0;
    for (int k = 0; k < 5; k++) begin
      b5 = put(b5, 11 + k, 0, 2'b01);
      b5 = put(b5, k, k, 2'b10);
    end
    b6 = '0;
    for (int c = 0; c < 5; c++) b6 = put(b6, 0, c, 2'b11);
    b7 = '0;
    for (int c = 9; c <= 15; c++) b7 = put(b7, 15, c, 2'b10);

    reset = 1'b1;
    start = 1'b0;
    board = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ans", int'(ans), 0);
    check("reset_dir", int'(win_dir), 0);
    reset = 1'b0;
    @(negedge clock);

    run_scan("empty",      '0, 0, 0, 0, 0, 0);
    run_scan("p0_row",     b1, 0, 1, 3, 2, 0);
    run_scan("p0_four",    b2, 0, 0, 0, 0, 0);
    run_scan("no_wrap",    b3, 0, 0, 0, 0, 0);
    run_scan("anti_diag",  b4, 0, 2, 4, 10, 3);
    run_scan("both",       b5, 0, 3, 0, 0, 2);
    run_scan("code11",     b6, 0, 0, 0, 0, 0);
    run_scan("overline",   b7, 0, 2, 15, 9, 0);
    run_scan("snapshot",   b1, 1, 1, 3, 2, 0);
    run_scan("restart",    b4, 2, 2, 4, 10, 3);
    run_scan("reset_mid",  b5, 3, 0, 0, 0, 0);
    run_scan("after_rst",  b5, 0, 3, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
